// File: rtl/line_track_pkg.sv
// Shared types for the line-tracking datapath (tracker bench and steering
// controller).
//   ctrl_state_t : steering controller mode, encoded as on the ctrl_state port
//   frame_smp_t  : one frame result as seen on the tracker interface
package line_track_pkg;

  localparam int STEER_W = 18;  // signed steering offset, servo clocks
  localparam int ERR_W   = 12;  // signed centre error / filter state
  localparam int CX_W    = 11;  // centroid column

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    HOLD   = 2'd2,
    SEARCH = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic [CX_W-1:0] cx;
    logic            lost;
  } frame_smp_t;

endpackage

// File: rtl/servo_pwm_gen.sv
// Hobby-servo pulse generator.
//   clk, rst  : clock, synchronous active-high reset
//   offset    : signed deviation from the neutral pulse, in clocks
//   servo_pwm : registered pulse train, one pulse per PWM_PERIOD
// The pulse width is captured only at the start of each period, so a change
// of offset mid-period never produces a truncated or stretched pulse.
module servo_pwm_gen
  import line_track_pkg::*;
#(
  parameter int PWM_PERIOD   = 1_000_000,
  parameter int PULSE_CENTER = 75_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [STEER_W-1:0] offset,
  output logic                      servo_pwm
);
  localparam int CNT_W = $clog2(PWM_PERIOD);
  // One bit wider than either operand so centre+offset never wraps.
  localparam int LAT_W = ((CNT_W > STEER_W) ? CNT_W : STEER_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_PERIOD - 1);
  localparam logic [LAT_W-1:0] LAT_RST  = LAT_W'(PULSE_CENTER);

  logic [CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [LAT_W-1:0] pulse_lat_q, pulse_lat_d;
  logic             servo_q, servo_d;

  always_comb begin
    pwm_cnt_d   = (pwm_cnt_q == CNT_LAST) ? '0 : pwm_cnt_q + CNT_W'(1);
    pulse_lat_d = pulse_lat_q;
    if (pwm_cnt_q == '0)
      pulse_lat_d = LAT_RST + {{(LAT_W-STEER_W){offset[STEER_W-1]}}, offset};
    // At count 0 the old width is compared; any legal width is > 0, so the
    // first high cycle is the same either way.
    servo_d = (LAT_W'(pwm_cnt_q) < pulse_lat_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q   <= '0;
      pulse_lat_q <= LAT_RST;
      servo_q     <= 1'b0;
    end else begin
      pwm_cnt_q   <= pwm_cnt_d;
      pulse_lat_q <= pulse_lat_d;
      servo_q     <= servo_d;
    end
  end

  assign servo_pwm = servo_q;

endmodule

// File: rtl/line_steer_ctrl.sv
// Steering controller fed by the ROI centroid tracker.
//   clk, rst    : clock, synchronous active-high reset
//   centroid_x  : frame centroid column
//   line_valid  : frame strobe (level; rising edge = one frame event)
//   line_lost   : no line found in this frame
//   steer_cmd   : clamped signed steering offset in servo clocks
//   cmd_valid   : one-cycle pulse per frame event, aligned with steer_cmd
//   servo_pwm   : servo pulse train
//   motor_en    : drive enable, high in TRACK and HOLD
//   ctrl_state  : IDLE/TRACK/HOLD/SEARCH
// Pipeline: input regs -> event/sample -> filter+FSM -> command/outputs.
module line_steer_ctrl
  import line_track_pkg::*;
#(
  parameter int IMG_W            = 640,
  parameter int PWM_PERIOD       = 1_000_000,
  parameter int PULSE_CENTER     = 75_000,
  parameter int PULSE_SPAN       = 25_000,
  parameter int ALPHA_SHIFT      = 2,
  parameter int KP_NUM           = 80,
  parameter int KP_SHIFT         = 2,
  parameter int LOST_HOLD_FRAMES = 4,
  parameter int WDOG_CYCLES      = 5_000_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CX_W-1:0]           centroid_x,
  input  logic                      line_valid,
  input  logic                      line_lost,
  output logic signed [STEER_W-1:0] steer_cmd,
  output logic                      cmd_valid,
  output logic                      servo_pwm,
  output logic                      motor_en,
  output logic [1:0]                ctrl_state
);
  localparam int LC_W = $clog2(LOST_HOLD_FRAMES + 1);
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  localparam logic signed [ERR_W-1:0]   CENTRE   = ERR_W'(IMG_W / 2);
  localparam logic [LC_W-1:0]           LOST_LIM = LC_W'(LOST_HOLD_FRAMES);
  localparam logic [WD_W-1:0]           WD_LAST  = WD_W'(WDOG_CYCLES - 1);
  localparam logic signed [STEER_W-1:0] SPAN_P   = STEER_W'(PULSE_SPAN);
  localparam logic signed [STEER_W-1:0] SPAN_N   = -SPAN_P;

  // input / event stage
  logic       lv_q, lv_d, lv_prev_q, lv_prev_d;
  frame_smp_t in_q, in_d, smp_q, smp_d;
  logic       evt;
  // [1] event seen by FSM, [2] FSM result, [3] cmd_valid
  logic [3:1] vld_pipe_q, vld_pipe_d;

  // filter / FSM stage
  ctrl_state_t              state_q, state_d;
  logic signed [ERR_W-1:0]  filt_q, filt_d, err, filt_upd;
  logic signed [ERR_W:0]    err_ext, filt_ext, diff, step;
  logic [LC_W-1:0]          lost_cnt_q, lost_cnt_d, lost_inc;
  logic [WD_W-1:0]          wdog_q, wdog_d;

  // command stage
  logic signed [31:0]         prod;
  logic signed [STEER_W-1:0]  prod_sat, steer_q, steer_d;
  logic                       motor_q, motor_d;

  always_comb begin
    lv_d       = line_valid;
    lv_prev_d  = lv_q;
    in_d       = '{cx: centroid_x, lost: line_lost};
    evt        = lv_q & ~lv_prev_q;
    smp_d      = evt ? in_q : smp_q;
    vld_pipe_d = {vld_pipe_q[2:1], evt};

    err      = $signed({1'b0, smp_q.cx}) - CENTRE;
    err_ext  = (ERR_W+1)'(err);
    filt_ext = (ERR_W+1)'(filt_q);
    diff     = err_ext - filt_ext;
    step     = diff >>> ALPHA_SHIFT;
    filt_upd = ERR_W'(filt_ext + step);
    lost_inc = lost_cnt_q + LC_W'(1);

    state_d    = state_q;
    filt_d     = filt_q;
    lost_cnt_d = lost_cnt_q;
    wdog_d     = wdog_q + WD_W'(1);

    // A frame event always beats a coincident watchdog expiry.
    if (vld_pipe_q[1]) begin
      wdog_d = '0;
      case (state_q)
        IDLE, SEARCH: begin
          if (!smp_q.lost) begin
            state_d = TRACK;
            filt_d  = err;  // seed: no history worth smoothing against
          end
        end
        TRACK: begin
          if (smp_q.lost) begin
            state_d    = HOLD;
            lost_cnt_d = LC_W'(1);
          end else begin
            filt_d = filt_upd;
          end
        end
        HOLD: begin
          if (!smp_q.lost) begin
            state_d    = TRACK;
            filt_d     = filt_upd;
            lost_cnt_d = '0;
          end else begin
            lost_cnt_d = lost_inc;
            if (lost_inc == LOST_LIM) state_d = SEARCH;
          end
        end
      endcase
    end else if (wdog_q == WD_LAST) begin
      state_d    = IDLE;
      filt_d     = '0;
      lost_cnt_d = '0;
      wdog_d     = '0;
    end
  end

  always_comb begin
    prod = (32'(filt_q) * KP_NUM) >>> KP_SHIFT;
    if (prod > PULSE_SPAN)       prod_sat = SPAN_P;
    else if (prod < -PULSE_SPAN) prod_sat = SPAN_N;
    else                         prod_sat = prod[STEER_W-1:0];

    steer_d = steer_q;
    case (state_q)
      IDLE:   steer_d = '0;
      TRACK:  steer_d = prod_sat;
      HOLD:   steer_d = steer_q;  // frozen at the last tracked value
      SEARCH: steer_d = filt_q[ERR_W-1] ? SPAN_N : SPAN_P;
    endcase
    motor_d = (state_q == TRACK) || (state_q == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lv_q       <= 1'b0;
      lv_prev_q  <= 1'b0;
      in_q       <= '0;
      smp_q      <= '0;
      vld_pipe_q <= '0;
      state_q    <= IDLE;
      filt_q     <= '0;
      lost_cnt_q <= '0;
      wdog_q     <= '0;
      steer_q    <= '0;
      motor_q    <= 1'b0;
    end else begin
      lv_q       <= lv_d;
      lv_prev_q  <= lv_prev_d;
      in_q       <= in_d;
      smp_q      <= smp_d;
      vld_pipe_q <= vld_pipe_d;
      state_q    <= state_d;
      filt_q     <= filt_d;
      lost_cnt_q <= lost_cnt_d;
      wdog_q     <= wdog_d;
      steer_q    <= steer_d;
      motor_q    <= motor_d;
    end
  end

  servo_pwm_gen #(
    .PWM_PERIOD  (PWM_PERIOD),
    .PULSE_CENTER(PULSE_CENTER)
  ) u_pwm (
    .clk      (clk),
    .rst      (rst),
    .offset   (steer_q),
    .servo_pwm(servo_pwm)
  );

  assign steer_cmd  = steer_q;
  assign cmd_valid  = vld_pipe_q[3];
  assign motor_en   = motor_q;
  assign ctrl_state = state_q;

endmodule

// File: tb/tb_line_steer_ctrl.sv
// Directed bench for line_steer_ctrl with a scaled-down servo timebase:
// period 4000, centre 2000, span 1800, watchdog 10000; gain 80/4 = 20.
module tb_line_steer_ctrl;
  localparam int PER  = 4000;
  localparam int WDOG = 10000;

  logic               clk = 1'b0;
  logic               rst;
  logic [10:0]        centroid_x;
  logic               line_valid;
  logic               line_lost;
  logic signed [17:0] steer_cmd;
  logic               cmd_valid;
  logic               servo_pwm;
  logic               motor_en;
  logic [1:0]         ctrl_state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  line_steer_ctrl #(
    .IMG_W(640), .PWM_PERIOD(PER), .PULSE_CENTER(2000), .PULSE_SPAN(1800),
    .ALPHA_SHIFT(2), .KP_NUM(80), .KP_SHIFT(2), .LOST_HOLD_FRAMES(4),
    .WDOG_CYCLES(WDOG)
  ) dut (
    .clk(clk), .rst(rst), .centroid_x(centroid_x), .line_valid(line_valid),
    .line_lost(line_lost), .steer_cmd(steer_cmd), .cmd_valid(cmd_valid),
    .servo_pwm(servo_pwm), .motor_en(motor_en), .ctrl_state(ctrl_state)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Starts a one-cycle frame at the current negedge; returns three cycles
  // after the sampling edge, where the command for that frame is visible.
  task automatic send(input int cx, input bit lost);
    centroid_x = 11'(cx);
    line_lost  = lost;
    line_valid = 1'b1;
    @(negedge clk);
    line_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Width of the next complete high pulse; a stuck output yields a wrong width.
  task automatic measure_pulse(output int hi);
    int guard;
    hi = 0;
    guard = 0;
    while (servo_pwm !== 1'b0 && guard < 3*PER) begin @(negedge clk); guard++; end
    while (servo_pwm !== 1'b1 && guard < 3*PER) begin @(negedge clk); guard++; end
    while (servo_pwm === 1'b1 && guard < 3*PER) begin hi++; @(negedge clk); guard++; end
  endtask

  initial begin
    int hi;
    int pulses;
    rst = 1'b1; line_valid = 1'b0; line_lost = 1'b0; centroid_x = '0;
    repeat (3) @(negedge clk);
    check("rst_steer", steer_cmd, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_servo", servo_pwm, 0);
    check("rst_motor", motor_en, 0);
    check("rst_state", ctrl_state, 0);
    rst = 1'b0;
    @(negedge clk);

    // Seed: err 80 -> filt 80 -> 80*80/4 = 1600, with latency checks
    centroid_x = 11'd400; line_lost = 1'b0; line_valid = 1'b1;
    @(negedge clk); line_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("seed_state_n2", ctrl_state, 1);
    check("seed_cv_n2", cmd_valid, 0);
    @(negedge clk);
    check("seed_steer_n3", steer_cmd, 1600);
    check("seed_cv_n3", cmd_valid, 1);
    check("seed_motor_n3", motor_en, 1);
    @(negedge clk);
    check("seed_cv_n4", cmd_valid, 0);
    measure_pulse(hi);
    check("seed_pulse", hi, 3600);

    // Filter step: err 0, filt 80 -> 60 -> 1200; held strobe gives one event
    centroid_x = 11'd320; line_valid = 1'b1; pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 7) line_valid = 1'b0;
      if (cmd_valid) pulses++;
    end
    check("step_steer", steer_cmd, 1200);
    check("step_one_cv", pulses, 1);

    // HOLD then non-lost: filter continues 60 -> 65 -> 1300 (reseed gives 1600)
    send(0, 1'b1);
    check("hold_state", ctrl_state, 2);
    check("hold_steer", steer_cmd, 1200);
    check("hold_cv", cmd_valid, 1);
    send(400, 1'b0);
    check("unhold_state", ctrl_state, 1);
    check("unhold_steer", steer_cmd, 1300);

    // Saturation boundary: filt +-90 gives exactly +-1800
    do_reset();
    send(410, 1'b0);
    check("bound_pos", steer_cmd, 1800);
    do_reset();
    send(230, 1'b0);
    check("bound_neg", steer_cmd, -1800);

    // Clamp: 319*20 = 6380 -> 1800; -320*20 -> -1800
    do_reset();
    send(639, 1'b0);
    check("clamp_pos", steer_cmd, 1800);
    measure_pulse(hi);
    check("clamp_pos_pulse", hi, 3800);
    do_reset();
    send(0, 1'b0);
    check("clamp_neg", steer_cmd, -1800);
    measure_pulse(hi);
    check("clamp_neg_pulse", hi, 200);

    // Lost recovery from filt -40 (steer -800)
    do_reset();
    send(280, 1'b0);
    check("lost_seed", steer_cmd, -800);
    send(0, 1'b1);
    send(0, 1'b1);
    send(0, 1'b1);
    check("lost3_state", ctrl_state, 2);
    check("lost3_steer", steer_cmd, -800);
    check("lost3_motor", motor_en, 1);
    send(0, 1'b1);
    check("lost4_state", ctrl_state, 3);
    check("lost4_steer", steer_cmd, -1800);
    check("lost4_motor", motor_en, 0);
    send(400, 1'b0);
    check("recover_state", ctrl_state, 1);
    check("recover_steer", steer_cmd, 1600);

    // Watchdog: event at edge N clears at N+2; expiry at edge N+2+WDOG
    send(320, 1'b0);
    check("wd_pre_steer", steer_cmd, 1200);
    repeat (WDOG - 2) @(negedge clk);
    check("wd_not_yet", ctrl_state, 1);
    @(negedge clk);
    check("wd_expired", ctrl_state, 0);
    @(negedge clk);
    check("wd_steer", steer_cmd, 0);
    check("wd_motor", motor_en, 0);

    // Event landing on the expiry edge keeps TRACK
    send(400, 1'b0);
    check("wd_reseed", steer_cmd, 1600);
    repeat (WDOG - 4) @(negedge clk);
    send(400, 1'b0);
    check("wd_coinc_state", ctrl_state, 1);
    check("wd_coinc_steer", steer_cmd, 1600);
    check("wd_coinc_cv", cmd_valid, 1);

    // Reset during a high pulse
    for (int i = 0; i < 2*PER && servo_pwm !== 1'b1; i++) @(negedge clk);
    check("pre_rst_high", servo_pwm, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_servo", servo_pwm, 0);
    check("midrst_steer", steer_cmd, 0);
    check("midrst_cv", cmd_valid, 0);
    check("midrst_motor", motor_en, 0);
    check("midrst_state", ctrl_state, 0);
    rst = 1'b0;
    measure_pulse(hi);
    check("post_rst_pulse", hi, 2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_steer_ctrl.md
# line_steer_ctrl

Downstream consumer of the ROI centroid tracker: converts each per-frame centroid result (`centroid_x`, `line_valid`, `line_lost`) into a servo steering command and a hobby-servo PWM output.

- Applies a centre-offset error, an exponential smoothing filter and a proportional gain with clamping.
- Runs a lost-line recovery state machine and a frame watchdog.
- Gates a motor enable so the vehicle stops when tracking is not trustworthy.

## Interface
Parameters:
- IMG_W, 640, image width; centre reference is IMG_W/2
- PWM_PERIOD, 1_000_000, servo period in clocks (20 ms at 50 MHz)
- PULSE_CENTER, 75_000, neutral pulse width in clocks (1.5 ms)
- PULSE_SPAN, 25_000, max steering deviation from centre in clocks
- ALPHA_SHIFT, 2, filter coefficient = 2^-ALPHA_SHIFT
- KP_NUM, 80, proportional gain numerator
- KP_SHIFT, 2, proportional gain = KP_NUM / 2^KP_SHIFT
- LOST_HOLD_FRAMES, 4, consecutive lost frames tolerated before SEARCH
- WDOG_CYCLES, 5_000_000, clocks without a frame event before returning to IDLE

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- centroid_x  in  11  frame centroid from the tracker
- line_valid  in  1  frame result strobe; may be held high for several cycles
- line_lost  in  1  qualifies line_valid: no line found this frame
- steer_cmd  out  18 signed  clamped deviation in clocks, range ±PULSE_SPAN
- cmd_valid  out  1  one-cycle pulse when steer_cmd updates
- servo_pwm  out  1  servo pulse train
- motor_en  out  1  high only in TRACK and HOLD
- ctrl_state  out  2  IDLE=0, TRACK=1, HOLD=2, SEARCH=3

## Operation
- **Frame event:** one-cycle pulse on the rising edge of `line_valid`, using a registered previous value. A held `line_valid` produces exactly one event. `centroid_x` and `line_lost` are sampled in the event cycle.
- **Error:** `err = centroid_x - IMG_W/2`, 12-bit signed, range -320..319.
- **Filter:** `filt <= filt + ((err - filt) >>> ALPHA_SHIFT)`, 13-bit signed intermediate, arithmetic (floor) shift. On IDLE→TRACK the filter is seeded with `filt <= err` instead.
- **Gain:** `prod = (filt * KP_NUM) >>> KP_SHIFT`, 32-bit signed. Saturate to ±PULSE_SPAN to give `steer_cmd`.
- **State machine** (transitions only on frame events, except the watchdog and reset):
  - IDLE: `steer_cmd` = 0, `motor_en` = 0.
    - Non-lost event → TRACK (seed filter).
    - Lost event → stay in IDLE.
  - TRACK: each non-lost event updates the filter and command.
    - Lost event → HOLD with `lost_cnt` = 1; command is unchanged.
  - HOLD: command frozen, `motor_en` = 1.
    - Non-lost event → TRACK, updating the filter normally (not reseeded); `lost_cnt` clears to 0.
    - Lost event → `lost_cnt`++. When `lost_cnt` reaches LOST_HOLD_FRAMES → SEARCH.
  - SEARCH: `steer_cmd` = +PULSE_SPAN if last `filt` ≥ 0, else -PULSE_SPAN. `motor_en` = 0.
    - Non-lost event → TRACK (seed filter).
- **Watchdog:** counter cleared by every frame event. Reaching WDOG_CYCLES forces IDLE: `filt` = 0, `steer_cmd` = 0. If the watchdog expires in the same cycle as an event, the event wins and the counter clears.
- **PWM:** free-running `pwm_cnt` 0..PWM_PERIOD-1.
  - `pulse_lat` = PULSE_CENTER + `steer_cmd`, latched only when `pwm_cnt` = 0, so there is never a partial or glitched pulse.
  - `servo_pwm` = (`pwm_cnt` < `pulse_lat`), registered.

## Timing
- **Reset values:** `steer_cmd` 0, `cmd_valid` 0, `servo_pwm` 0, `motor_en` 0, `ctrl_state` IDLE. `filt`, `lost_cnt`, `pwm_cnt` and watchdog are all 0; `pulse_lat` = PULSE_CENTER.
- **Latency:** `line_valid` rising at edge N → event at N+1 → `filt` and state at N+2 → `steer_cmd`, `cmd_valid` and `motor_en` at N+3.
- `cmd_valid` pulses on every event (including lost events and IDLE/SEARCH outputs), exactly one cycle wide.
- A new `steer_cmd` reaches `servo_pwm` at the next `pwm_cnt` = 0 wrap. Worst case is PWM_PERIOD+1 cycles.
- **Reset mid-period:** `servo_pwm` is low at the next edge and the PWM restarts at `pwm_cnt` = 0.
- **Saturation boundary:** a `prod` of exactly ±PULSE_SPAN passes unchanged.

## Structure
- Package `line_track_pkg`: `ctrl_state_t` enum (IDLE, TRACK, HOLD, SEARCH), `STEER_W` = 18, `ERR_W` = 12. This package is shared with the tracker testbench.
- Sub-module `servo_pwm_gen`: period counter, boundary latch, and compare. Parameters PWM_PERIOD and PULSE_CENTER; input is the signed offset.
- The top level holds edge detect, filter/gain pipeline, FSM and watchdog.

## Test plan
- **Seed and gain:** reset, then non-lost `centroid_x` = 400 → TRACK; `steer_cmd` = 1600 and `cmd_valid` at N+3. Next PWM period is high for 76_600 clocks.
- **Filter step:** after the previous frame, `centroid_x` = 320 → `filt` 80→60, `steer_cmd` = 1200. Hold `line_valid` high for 8 cycles → exactly one `cmd_valid`.
- **Clamp:** with KP_NUM = 400, `centroid_x` = 639 → `prod` 31_900, so `steer_cmd` = 25_000 and the pulse is 100_000 clocks. With `centroid_x` = 0 → -25_000 and the pulse is 50_000.
- **Lost recovery:** from TRACK with `filt` = -40:
  - Three lost frames → HOLD, `steer_cmd` unchanged, `motor_en` = 1.
  - Fourth lost frame → SEARCH, `steer_cmd` = -25_000, `motor_en` = 0.
  - A non-lost frame → TRACK with the filter reseeded.
- **Watchdog:** WDOG_CYCLES = 1000, no events for 1000 clocks → IDLE with `steer_cmd` = 0. An event coincident with expiry keeps the current state.
- **Reset mid-pulse:** assert `rst` while `servo_pwm` = 1 → all outputs are at reset values the next cycle, and the first post-reset pulse is 75_000 clocks.
